// File: rtl/video_test_pattern_gen.sv
// video_test_pattern_gen
//   Multi-mode test pattern source in the pixel clock domain, feeding the DVI
//   encoder. Mode, data word and active window are latched on frame_start, so
//   a frame is never torn. Output latency is fixed at LATENCY cycles. de_out is
//   de delayed by the same amount.
//
// Ports
//   pclk, reset_n              pixel clock, async active-low reset
//   frame_start                one-cycle pulse on the first pixel of a frame
//   de, px, py                 display enable and coordinate of current pixel
//   xstart/xend/ystart/yend    inclusive active window (latched per frame)
//   mode                       0 grid, 1 bars, 2 checker, 3 solid, 4 data,
//                              5 bouncing box, 6/7 black
//   data                       word shown in data-dump mode
//   r, g, b, de_out            pixel colour and delayed display enable
//   frame_cnt                  frames since reset (wraps)
module video_test_pattern_gen #(
    parameter int CW        = 11,
    parameter int COL_W     = 8,
    parameter int DATA_W    = 64,
    parameter int LATENCY   = 4,
    parameter int BAR_SHIFT = 6,
    parameter int CHK_SHIFT = 4,
    parameter int BOX_SIZE  = 32,
    parameter int STEP      = 2,
    parameter int FCNT_W    = 16
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              de,
    input  logic [CW-1:0]     px,
    input  logic [CW-1:0]     py,
    input  logic [CW-1:0]     xstart,
    input  logic [CW-1:0]     xend,
    input  logic [CW-1:0]     ystart,
    input  logic [CW-1:0]     yend,
    input  logic [2:0]        mode,
    input  logic [DATA_W-1:0] data,
    output logic [COL_W-1:0]  r,
    output logic [COL_W-1:0]  g,
    output logic [COL_W-1:0]  b,
    output logic              de_out,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int IW = $clog2(DATA_W);
    localparam int PW = 3*COL_W + 1;
    localparam logic [CW:0] BOX_W  = (CW+1)'(BOX_SIZE);
    localparam logic [CW:0] STEP_W = (CW+1)'(STEP);
    localparam logic [COL_W-1:0] WHITE   = {COL_W{1'b1}};
    localparam logic [COL_W-1:0] GREY_HI = {1'b1, {(COL_W-1){1'b0}}};
    localparam logic [COL_W-1:0] GREY_LO = {2'b01, {(COL_W-2){1'b0}}};

    // Frame-latched state
    logic [2:0]        mode_r;
    logic [DATA_W-1:0] data_r;
    logic [CW-1:0]     xstart_r, xend_r, ystart_r, yend_r;
    logic [CW-1:0]     box_x, box_y;
    logic              box_xneg, box_yneg;

    // Returns {direction_is_negative, new_position}. Arithmetic is one bit
    // wider than the coordinates so end+1 and pos+STEP+BOX never wrap.
    function automatic logic [CW:0] box_step(input logic [CW-1:0] pos,
                                             input logic          neg,
                                             input logic [CW-1:0] lo,
                                             input logic [CW-1:0] hi);
        logic [CW:0]   p, l, h1;
        logic [CW-1:0] nxt;
        logic [CW:0]   res;
        p   = {1'b0, pos};
        l   = {1'b0, lo};
        h1  = {1'b0, hi} + (CW+1)'(1);
        res = {neg, pos};
        if (h1 < l + BOX_W) begin
            res = {neg, lo};
        end else if (!neg) begin
            if (p + STEP_W + BOX_W > h1) begin
                nxt = CW'(h1 - BOX_W);
                res = {1'b1, nxt};
            end else begin
                nxt = CW'(p + STEP_W);
                res = {1'b0, nxt};
            end
        end else begin
            if (p < l + STEP_W) begin
                res = {1'b0, lo};
            end else begin
                nxt = CW'(p - STEP_W);
                res = {1'b1, nxt};
            end
        end
        return res;
    endfunction

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            mode_r    <= '0;
            data_r    <= '0;
            xstart_r  <= '0;
            xend_r    <= '0;
            ystart_r  <= '0;
            yend_r    <= '0;
            frame_cnt <= '0;
            box_x     <= '0;
            box_y     <= '0;
            box_xneg  <= 1'b0;
            box_yneg  <= 1'b0;
        end else if (frame_start) begin
            mode_r    <= mode;
            data_r    <= data;
            xstart_r  <= xstart;
            xend_r    <= xend;
            ystart_r  <= ystart;
            yend_r    <= yend;
            frame_cnt <= frame_cnt + FCNT_W'(1);
            // Box steps within the window of the frame just ending.
            {box_xneg, box_x} <= box_step(box_x, box_xneg, xstart_r, xend_r);
            {box_yneg, box_y} <= box_step(box_y, box_yneg, ystart_r, yend_r);
        end
    end

    // Stage 1: coordinates plus every decision that depends on frame-latched
    // state, so the pixel coinciding with frame_start sees the old frame.
    logic [CW-1:0] xoff, yoff;
    logic          in_win, on_line, chk_bit, data_bit, in_box;

    always_comb begin
        xoff     = px - xstart_r;
        yoff     = py - ystart_r;
        in_win   = (px >= xstart_r) && (px <= xend_r) &&
                   (py >= ystart_r) && (py <= yend_r);
        on_line  = (px == xstart_r) || (px == xend_r) ||
                   (py == ystart_r) || (py == yend_r) ||
                   (px[7:0] == 8'd0) || (py[7:0] == 8'd0);
        chk_bit  = xoff[CHK_SHIFT] ^ yoff[CHK_SHIFT] ^ frame_cnt[5];
        data_bit = data_r[xoff[3 +: IW]];
        in_box   = (px >= box_x) && ({1'b0, px} < {1'b0, box_x} + BOX_W) &&
                   (py >= box_y) && ({1'b0, py} < {1'b0, box_y} + BOX_W);
    end

    logic             s1_de, s1_win, s1_line, s1_chk, s1_dbit, s1_box;
    logic [COL_W:0]   s1_px, s1_py;
    logic [CW-1:0]    s1_xoff, s1_yoff;
    logic [2:0]       s1_mode;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            s1_de   <= 1'b0;
            s1_px   <= '0;
            s1_py   <= '0;
            s1_xoff <= '0;
            s1_yoff <= '0;
            s1_mode <= '0;
            s1_win  <= 1'b0;
            s1_line <= 1'b0;
            s1_chk  <= 1'b0;
            s1_dbit <= 1'b0;
            s1_box  <= 1'b0;
        end else begin
            s1_de   <= de;
            s1_px   <= px[COL_W:0];
            s1_py   <= py[COL_W:0];
            s1_xoff <= xoff;
            s1_yoff <= yoff;
            s1_mode <= mode_r;
            s1_win  <= in_win;
            s1_line <= on_line;
            s1_chk  <= chk_bit;
            s1_dbit <= data_bit;
            s1_box  <= in_box;
        end
    end

    // Stage 2: colour
    logic [COL_W-1:0] cr, cg, cb, sfill;
    logic [COL_W:0]   pxy;
    logic [2:0]       bar_c;
    logic [PW-1:0]    pix_next;

    always_comb begin
        cr       = '0;
        cg       = '0;
        cb       = '0;
        sfill    = s1_line ? WHITE : '0;
        pxy      = s1_px ^ s1_py;
        bar_c    = ~s1_xoff[BAR_SHIFT +: 3];
        case (s1_mode)
            3'd0: begin
                cr = s1_px[COL_W-1:0] | sfill;
                cg = s1_py[COL_W-1:0] | sfill;
                cb = pxy[COL_W:1]     | sfill;
            end
            3'd1: if (s1_win) begin
                cr = {COL_W{bar_c[2]}};
                cg = {COL_W{bar_c[1]}};
                cb = {COL_W{bar_c[0]}};
            end
            3'd2: if (s1_win && s1_chk) begin
                cr = WHITE; cg = WHITE; cb = WHITE;
            end
            3'd3: if (s1_win) begin
                cr = WHITE; cg = WHITE; cb = WHITE;
            end
            3'd4: if (s1_win && ({1'b0, s1_xoff} < (CW+1)'(8*DATA_W))) begin
                if (s1_yoff < CW'(32)) begin
                    if (s1_dbit) begin
                        cr = WHITE; cg = WHITE; cb = WHITE;
                    end
                end else if (s1_yoff < CW'(64)) begin
                    cr = s1_xoff[3] ? GREY_HI : GREY_LO;
                    cg = cr;
                    cb = cr;
                end
            end
            3'd5: if (s1_win && s1_box) begin
                cr = WHITE; cg = WHITE; cb = WHITE;
            end
            default: ;
        endcase
        pix_next = s1_de ? {1'b1, cr, cg, cb} : '0;
    end

    // Stage 2 register followed by LATENCY-2 delay stages.
    logic [PW-1:0] dly [LATENCY-1];

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < LATENCY-1; k++) dly[k] <= '0;
        end else begin
            dly[0] <= pix_next;
            for (int k = 1; k < LATENCY-1; k++) dly[k] <= dly[k-1];
        end
    end

    assign {de_out, r, g, b} = dly[LATENCY-2];

endmodule

// File: tb/tb_video_test_pattern_gen.sv
// Testbench for video_test_pattern_gen: a pixel-level reference model computes
// each expected colour from the frame state it latched itself; the expected
// pixels are queued and compared LATENCY cycles later.
module tb_video_test_pattern_gen;

    localparam int CW     = 11;
    localparam int COL_W  = 8;
    localparam int DATA_W = 64;
    localparam int LAT    = 4;
    localparam int BOX    = 32;
    localparam int STP    = 2;
    localparam int FCW    = 16;

    typedef logic [3*COL_W:0] pix_t;

    logic              pclk = 1'b0;
    logic              reset_n;
    logic              frame_start;
    logic              de;
    logic [CW-1:0]     px, py, xstart, xend, ystart, yend;
    logic [2:0]        mode;
    logic [DATA_W-1:0] data;
    logic [COL_W-1:0]  r, g, b;
    logic              de_out;
    logic [FCW-1:0]    frame_cnt;

    video_test_pattern_gen #(.LATENCY(LAT)) dut (
        .pclk(pclk), .reset_n(reset_n), .frame_start(frame_start), .de(de),
        .px(px), .py(py), .xstart(xstart), .xend(xend), .ystart(ystart),
        .yend(yend), .mode(mode), .data(data), .r(r), .g(g), .b(b),
        .de_out(de_out), .frame_cnt(frame_cnt)
    );

    always #5 pclk = ~pclk;

    int n_asrt = 0;
    int n_fail = 0;

    // Reference model state
    int          m_mode, m_xs, m_xe, m_ys, m_ye, m_fc;
    logic [63:0] m_data;
    int          m_bx, m_by;
    bit          m_xneg, m_yneg;
    pix_t        q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_xs = 0; m_xe = 0; m_ys = 0; m_ye = 0; m_fc = 0;
        m_data = '0; m_bx = 0; m_by = 0; m_xneg = 0; m_yneg = 0;
        q.delete();
        repeat (LAT-1) q.push_back('0);
    endtask

    task automatic step_axis(input int pos, input bit neg, input int lo, input int hi,
                             output int npos, output bit nneg);
        npos = pos; nneg = neg;
        if (hi + 1 - lo < BOX) npos = lo;
        else if (!neg) begin
            if (pos + STP + BOX > hi + 1) begin npos = hi + 1 - BOX; nneg = 1; end
            else npos = pos + STP;
        end else begin
            if (pos < lo + STP) begin npos = lo; nneg = 0; end
            else npos = pos - STP;
        end
    endtask

    task automatic frame_latch();
        int  nx, ny;
        bit  dx, dy;
        step_axis(m_bx, m_xneg, m_xs, m_xe, nx, dx);
        step_axis(m_by, m_yneg, m_ys, m_ye, ny, dy);
        m_bx = nx; m_xneg = dx; m_by = ny; m_yneg = dy;
        m_mode = int'(mode); m_data = data;
        m_xs = int'(xstart); m_xe = int'(xend); m_ys = int'(ystart); m_ye = int'(yend);
        m_fc = (m_fc + 1) % (1 << FCW);
    endtask

    function automatic pix_t exp_pix(input int x, input int y, input bit d);
        int rr, gg, bb, xo, yo, c, v;
        bit inw, s;
        rr = 0; gg = 0; bb = 0;
        if (!d) return '0;
        xo  = (x - m_xs) & 2047;
        yo  = (y - m_ys) & 2047;
        inw = (x >= m_xs) && (x <= m_xe) && (y >= m_ys) && (y <= m_ye);
        case (m_mode)
            0: begin
                s  = (x == m_xs) || (x == m_xe) || (y == m_ys) || (y == m_ye) ||
                     (x % 256 == 0) || (y % 256 == 0);
                rr = s ? 255 : x % 256;
                gg = s ? 255 : y % 256;
                bb = s ? 255 : ((x ^ y) >> 1) % 256;
            end
            1: if (inw) begin
                c  = 7 - ((xo >> 6) % 8);
                rr = (c & 4) ? 255 : 0;
                gg = (c & 2) ? 255 : 0;
                bb = (c & 1) ? 255 : 0;
            end
            2: if (inw && ((((xo >> 4) ^ (yo >> 4) ^ (m_fc >> 5)) & 1) == 1)) begin
                rr = 255; gg = 255; bb = 255;
            end
            3: if (inw) begin rr = 255; gg = 255; bb = 255; end
            4: if (inw && xo < 8 * DATA_W) begin
                if (yo < 32) begin
                    if (m_data[xo / 8]) begin rr = 255; gg = 255; bb = 255; end
                end else if (yo < 64) begin
                    v = (xo & 8) ? 128 : 64;
                    rr = v; gg = v; bb = v;
                end
            end
            5: if (inw && x >= m_bx && x < m_bx + BOX && y >= m_by && y < m_by + BOX) begin
                rr = 255; gg = 255; bb = 255;
            end
            default: ;
        endcase
        return {1'b1, 8'(rr), 8'(gg), 8'(bb)};
    endfunction

    // One pixel clock: drive at negedge, check the pixel issued LAT-1 cycles ago.
    task automatic cyc(input bit fs, input bit d, input int x, input int y);
        x = x & 2047;
        y = y & 2047;
        @(negedge pclk);
        frame_start = fs; de = d; px = CW'(x); py = CW'(y);
        q.push_back(exp_pix(x, y, d));
        if (fs) frame_latch();
        @(posedge pclk);
        #1;
        check("pixel", {de_out, r, g, b}, q.pop_front());
        check("frame_cnt", frame_cnt, m_fc);
    endtask

    task automatic new_frame(input int md, input int xs, input int xe, input int ys, input int ye);
        mode = 3'(md); xstart = CW'(xs); xend = CW'(xe); ystart = CW'(ys); yend = CW'(ye);
        cyc(1, 0, 0, 0);
    endtask

    task automatic box_probe();
        int bx, by;
        bx = m_bx; by = m_by;
        cyc(0, 1, bx - 1, by + 1);
        cyc(0, 1, bx, by + 1);
        cyc(0, 1, bx + BOX - 1, by + 1);
        cyc(0, 1, bx + BOX, by + 1);
        cyc(0, 1, bx + 1, by - 1);
        cyc(0, 1, bx + 1, by);
        cyc(0, 1, bx + 1, by + BOX - 1);
        cyc(0, 1, bx + 1, by + BOX);
    endtask

    initial begin
        int fc_before;
        reset_n = 1'b0; frame_start = 0; de = 0; px = '0; py = '0;
        xstart = '0; xend = '0; ystart = '0; yend = '0; mode = '0; data = '0;
        model_reset();
        #2;
        check("reset_rgb", {de_out, r, g, b}, '0);
        check("reset_fcnt", frame_cnt, '0);
        @(negedge pclk);
        reset_n = 1'b1;

        // Latency: single de pulse in solid mode
        new_frame(3, 0, 639, 0, 479);
        cyc(0, 0, 5, 10);
        cyc(0, 1, 10, 10);
        repeat (6) cyc(0, 0, 11, 10);

        // Colour bars
        new_frame(1, 0, 511, 0, 479);
        cyc(0, 1, 64, 20);
        cyc(0, 1, 448, 20);
        cyc(0, 1, 600, 20);
        repeat (30) cyc(0, 1, $urandom_range(0, 700), $urandom_range(0, 500));

        // Data dump
        data = 64'h1;
        new_frame(4, 100, 800, 100, 400);
        for (int x = 100; x <= 108; x++) cyc(0, 1, x, 110);
        cyc(0, 1, 108, 140);
        cyc(0, 1, 100, 140);
        cyc(0, 1, 100, 170);
        data = {$urandom, $urandom};
        new_frame(4, 100, 800, 100, 400);
        repeat (80) cyc(0, 1, $urandom_range(90, 640), $urandom_range(95, 175));

        // Frame latching: inputs change mid-frame, latched only on frame_start
        new_frame(0, 50, 300, 40, 200);
        repeat (10) cyc(0, 1, $urandom_range(0, 400), $urandom_range(0, 300));
        mode = 3'd1; xstart = CW'(0); xend = CW'(511); ystart = CW'(0); yend = CW'(479);
        cyc(0, 1, 50, 100);
        cyc(0, 1, 256, 70);
        repeat (10) cyc(0, 1, $urandom_range(0, 400), $urandom_range(0, 300));
        fc_before = int'(frame_cnt);
        cyc(1, 1, 120, 90);
        check("fcnt_step", frame_cnt, FCW'(fc_before + 1));
        repeat (10) cyc(0, 1, $urandom_range(0, 400), $urandom_range(0, 300));

        // Checkerboard over enough frames for the frame_cnt[5] inversion
        for (int f = 0; f < 70; f++) begin
            new_frame(2, 0, 639, 0, 479);
            repeat (3) cyc(0, 1, $urandom_range(0, 639), $urandom_range(0, 479));
        end

        // Bouncing box in a 100x80 window, then a window narrower than the box
        for (int f = 0; f < 45; f++) begin
            new_frame(5, 0, 99, 0, 79);
            box_probe();
        end
        for (int f = 0; f < 6; f++) begin
            new_frame(5, 10, 30, 10, 90);
            box_probe();
        end

        // Random frames, modes, windows and pixels
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                int xs, ys;
                xs = $urandom_range(0, 600);
                ys = $urandom_range(0, 400);
                data = {$urandom, $urandom};
                new_frame($urandom_range(0, 7), xs, xs + $urandom_range(0, 700),
                          ys, ys + $urandom_range(0, 500));
            end else if ($urandom_range(0, 9) == 0) begin
                cyc(0, 1, m_xs, $urandom_range(0, 900));
            end else begin
                cyc(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1400), $urandom_range(0, 900));
            end
        end

        // Asynchronous reset mid-line with the box active
        new_frame(5, 0, 639, 0, 479);
        new_frame(5, 0, 639, 0, 479);
        for (int x = 0; x < 12; x++) cyc(0, 1, x, 3);
        #2;
        reset_n = 1'b0;
        frame_start = 0; de = 0;
        #1;
        check("async_rst_rgb", {de_out, r, g, b}, '0);
        check("async_rst_fcnt", frame_cnt, '0);
        model_reset();
        #2;
        reset_n = 1'b1;
        q.push_back('0);
        @(posedge pclk);
        #1;
        check("post_reset_pix", {de_out, r, g, b}, q.pop_front());
        check("post_reset_fcnt", frame_cnt, m_fc);
        for (int f = 0; f < 8; f++) begin
            new_frame(5, 0, 639, 0, 479);
            box_probe();
        end
        repeat (LAT) cyc(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
